sm3_msg_expansion_stream: RTL and testbench
===========================================

Name: sm3_msg_expansion_stream

Overview:
Parametrised, flow-controlled successor to the SM3 message expander. It accepts a 512-bit padded block with a valid/ready handshake and streams (j, W_j, W'_j) beats to the compression round logic under output backpressure. An optional shadow block register accepts the next block during expansion, so consecutive blocks stream with zero bubble cycles. A synchronous abort is also provided.

Parameters:
ROUNDS, 64, number of (W_j, W'_j) beats per block; legal range 1..64.
IDX_W, 6, width of index_out; must satisfy 2^IDX_W >= ROUNDS.
PRELOAD, 1, 1 = shadow block register present (double buffering); 0 = a block is accepted only when idle.

Ports:
clk_in  input  1  clock; all logic is on the rising edge.
reset_in  input  1  asynchronous, active-high reset.
msg_in  input  512  padded block; msg_in[511:480] = W0 ... msg_in[31:0] = W15.
msg_valid_in  input  1  msg_in is valid.
msg_ready_out  output  1  a block can be accepted this cycle.
abort_in  input  1  synchronous flush of all in-flight work.
word_valid_out  output  1  the output beat is valid.
word_ready_in  input  1  the consumer takes the beat.
word_out  output  32  W_j.
word_p_out  output  32  W'_j = W_j ^ W_{j+4}.
index_out  output  IDX_W  j of the current beat.
last_out  output  1  beat is j == ROUNDS-1.
busy_out  output  1  state == RUN, or word_valid_out, or shadow full.

Behaviour:
- Reset (async, on assertion):
  - window w0..w15 = 0, shadow = 0, shadow_valid = 0.
  - state = IDLE, word_valid_out = 0.
  - word_out, word_p_out, index_out, last_out = 0.
- Handshakes:
  - Block accept = msg_valid_in && msg_ready_out.
  - Beat transfer = word_valid_out && word_ready_in.
  - adv = !word_valid_out || word_ready_in.
- msg_ready_out is combinational: !abort_in && (state == IDLE || (PRELOAD && !shadow_valid)).
- Expansion, evaluated on the window:
  - x = w0 ^ w7 ^ rotl(w13, 15).
  - P1(x) = x ^ rotl(x, 15) ^ rotl(x, 23).
  - new = P1(x) ^ rotl(w3, 7) ^ w10.
  - All arithmetic is 32-bit XOR/rotate only.
- State machine, states IDLE and RUN, internal counter cnt:
  - IDLE, block accept: window <= msg_in, cnt <= 0, go to RUN. The accepted block bypasses the shadow.
  - RUN with adv high:
    - output regs <= {w0, w0 ^ w4, cnt, cnt == ROUNDS-1}; word_valid_out <= 1.
    - window shifts left, w15 <= new; cnt++.
  - RUN, final beat issued (cnt == ROUNDS-1) and adv:
    - if shadow_valid: window <= shadow, shadow_valid <= 0, cnt <= 0, stay in RUN.
    - else: go to IDLE.
  - RUN with PRELOAD=1 and block accept: shadow <= msg_in, shadow_valid <= 1.
    - If this coincides with the final-beat adv while shadow is empty, msg_in goes directly into the window and state stays RUN.
  - IDLE with adv and no new beat: word_valid_out <= 0 once the last beat has been taken.
- Latency and stalls:
  - Block accepted at edge t gives the first beat valid after edge t+1.
  - With word_ready_in held high, beats follow one per cycle.
  - Back-to-back blocks have 0 gap cycles when PRELOAD=1.
  - While word_valid_out && !word_ready_in, all outputs, the window and cnt hold stable.
- abort_in (highest priority below reset):
  - next edge: state = IDLE, word_valid_out = 0, shadow_valid = 0, cnt = 0.
  - data registers keep their values.
  - Any block presented in the abort cycle is not accepted.
- Boundary cases:
  - ROUNDS=1: a single beat carrying last_out = 1.
  - ROUNDS <= 12: W'_j depends only on message words, but the window still shifts.
  - PRELOAD=0: msg_ready_out is low throughout RUN.

Test Plan:
- "abc" block (61626380, 0 ×14, 00000018), word_ready_in = 1:
  - beat0 = {W 61626380, W' 61626380, j 0}.
  - beat12 W' = 9092E200; beat16 W = 9092E200; beat18 W = 000C0606.
  - beat63 has last_out = 1, then word_valid_out drops and busy_out = 0.
- Backpressure: word_ready_in toggled 1/0 randomly on the "abc" block -> identical 64-beat sequence with no drops or duplicates; outputs stable during each stall.
- PRELOAD=1, two blocks presented back-to-back:
  - the second block is accepted during beat ~2 of the first.
  - beat0 of block 2 immediately follows beat63 of block 1 (0 gap).
  - msg_ready_out = 0 while the shadow is full.
- PRELOAD=0, same stimulus -> second block accepted only after the first finishes; msg_ready_out low throughout RUN.
- abort_in pulsed at beat 20 with the shadow full -> next cycle word_valid_out = 0, state IDLE, msg_ready_out = 1; a fresh block restarts at j = 0.
- reset_in asserted mid-RUN (asynchronously, between edges) -> all outputs 0 immediately; ROUNDS=1 build yields one beat with last_out = 1.

Source files
------------

// File: rtl/sm3_msg_expansion_stream.sv
// SM3 message expander with valid/ready block input and backpressured (j, W_j, W'_j) beat output.
// Optional shadow block register lets the next block follow the current one without a bubble.
`timescale 1ns/1ps
module sm3_msg_expansion_stream #(
   parameter int unsigned ROUNDS  = 64,
   parameter int unsigned IDX_W   = 6,
   parameter int unsigned PRELOAD = 1
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic [511:0]      msg_in,
   input  logic              msg_valid_in,
   output logic              msg_ready_out,
   input  logic              abort_in,
   output logic              word_valid_out,
   input  logic              word_ready_in,
   output logic [31:0]       word_out,
   output logic [31:0]       word_p_out,
   output logic [IDX_W-1:0]  index_out,
   output logic              last_out,
   output logic              busy_out
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned NWORDS = 16;
   localparam int unsigned BLK_W  = WORD_W * NWORDS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);
   localparam logic HAS_SHADOW = (PRELOAD != 0);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [WORD_W-1:0]   win_q [NWORDS];
   logic [WORD_W-1:0]   win_d [NWORDS];
   logic [BLK_W-1:0]    shadow_q, shadow_d;
   logic                shadow_valid_q, shadow_valid_d;
   logic [IDX_W-1:0]    cnt_q, cnt_d;
   logic                wvalid_q, wvalid_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   wordp_q, wordp_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                last_q, last_d;

   logic                accept, adv, final_beat;
   logic [WORD_W-1:0]   x_mix, p1_x, new_w;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v, input int unsigned n);
      rotl = (v << n) | (v >> (WORD_W - n));
   endfunction

   // Next expanded word computed from the current 16-word window.
   assign x_mix = win_q[0] ^ win_q[7] ^ rotl(win_q[13], 15);
   assign p1_x  = x_mix ^ rotl(x_mix, 15) ^ rotl(x_mix, 23);
   assign new_w = p1_x ^ rotl(win_q[3], 7) ^ win_q[10];

   assign msg_ready_out = !abort_in && (state_q == IDLE || (HAS_SHADOW && !shadow_valid_q));
   assign accept        = msg_valid_in && msg_ready_out;
   assign adv           = !wvalid_q || word_ready_in;
   assign final_beat    = (cnt_q == LAST_IDX);

   assign word_valid_out = wvalid_q;
   assign word_out       = word_q;
   assign word_p_out     = wordp_q;
   assign index_out      = idx_q;
   assign last_out       = last_q;
   assign busy_out       = (state_q == RUN) || wvalid_q || shadow_valid_q;

   always_comb begin
      state_d        = state_q;
      win_d          = win_q;
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      cnt_d          = cnt_q;
      wvalid_d       = wvalid_q;
      word_d         = word_q;
      wordp_d        = wordp_q;
      idx_d          = idx_q;
      last_d         = last_q;

      if (abort_in) begin
         state_d        = IDLE;
         wvalid_d       = 1'b0;
         shadow_valid_d = 1'b0;
         cnt_d          = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (adv) wvalid_d = 1'b0;
               if (accept) begin
                  for (int i = 0; i < NWORDS; i++) win_d[i] = msg_in[BLK_W-1-WORD_W*i -: WORD_W];
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  shadow_d       = msg_in;
                  shadow_valid_d = 1'b1;
               end
               if (adv) begin
                  wvalid_d = 1'b1;
                  word_d   = win_q[0];
                  wordp_d  = win_q[0] ^ win_q[4];
                  idx_d    = cnt_q;
                  last_d   = final_beat;
                  for (int i = 0; i < NWORDS - 1; i++) win_d[i] = win_q[i+1];
                  win_d[NWORDS-1] = new_w;
                  cnt_d = cnt_q + IDX_W'(1);
                  // End of block: chain the shadow, or a block arriving this very cycle, straight in.
                  if (final_beat) begin
                     cnt_d = '0;
                     if (shadow_valid_q) begin
                        for (int i = 0; i < NWORDS; i++) win_d[i] = shadow_q[BLK_W-1-WORD_W*i -: WORD_W];
                        shadow_valid_d = 1'b0;
                     end else if (accept) begin
                        for (int i = 0; i < NWORDS; i++) win_d[i] = msg_in[BLK_W-1-WORD_W*i -: WORD_W];
                        shadow_valid_d = 1'b0;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q        <= IDLE;
         for (int i = 0; i < NWORDS; i++) win_q[i] <= '0;
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
         cnt_q          <= '0;
         wvalid_q       <= 1'b0;
         word_q         <= '0;
         wordp_q        <= '0;
         idx_q          <= '0;
         last_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         for (int i = 0; i < NWORDS; i++) win_q[i] <= win_d[i];
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
         cnt_q          <= cnt_d;
         wvalid_q       <= wvalid_d;
         word_q         <= word_d;
         wordp_q        <= wordp_d;
         idx_q          <= idx_d;
         last_q         <= last_d;
      end
   end

endmodule

// File: tb/tb_sm3_msg_expansion_stream.sv
// Scoreboard bench for sm3_msg_expansion_stream: default, PRELOAD=0 and ROUNDS=1 builds
// share one stimulus driver and one output monitor through a select mux.
`timescale 1ns/1ps
module tb_sm3_msg_expansion_stream;

   typedef struct packed {
      logic [31:0] w;
      logic [31:0] wp;
      logic [5:0]  idx;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic [511:0] msg = '0;
   logic         b_valid = 1'b0;
   logic         b_abort = 1'b0;
   logic         b_ready;
   logic         bp_en = 1'b0;
   int           sel = 0;

   logic v0, v1, v2, r0, r1, r2, a0, a1, a2;
   logic rdy0, rdy1, rdy2, wv0, wv1, wv2, l0, l1, l2, bz0, bz1, bz2;
   logic [31:0] w0, w1, w2, p0, p1, p2;
   logic [5:0]  i0, i1;
   logic [0:0]  i2;

   logic        m_ready, m_wvalid, m_last, m_busy;
   logic [31:0] m_word, m_wordp;
   logic [5:0]  m_idx;

   assign v0 = (sel == 0) && b_valid;
   assign v1 = (sel == 1) && b_valid;
   assign v2 = (sel == 2) && b_valid;
   assign a0 = (sel == 0) && b_abort;
   assign a1 = (sel == 1) && b_abort;
   assign a2 = (sel == 2) && b_abort;
   assign r0 = (sel == 0) ? b_ready : 1'b1;
   assign r1 = (sel == 1) ? b_ready : 1'b1;
   assign r2 = (sel == 2) ? b_ready : 1'b1;

   sm3_msg_expansion_stream #(.ROUNDS(64), .IDX_W(6), .PRELOAD(1)) dut (
      .clk_in(clk), .reset_in(rst), .msg_in(msg), .msg_valid_in(v0), .msg_ready_out(rdy0),
      .abort_in(a0), .word_valid_out(wv0), .word_ready_in(r0), .word_out(w0), .word_p_out(p0),
      .index_out(i0), .last_out(l0), .busy_out(bz0));

   sm3_msg_expansion_stream #(.ROUNDS(64), .IDX_W(6), .PRELOAD(0)) dut_np (
      .clk_in(clk), .reset_in(rst), .msg_in(msg), .msg_valid_in(v1), .msg_ready_out(rdy1),
      .abort_in(a1), .word_valid_out(wv1), .word_ready_in(r1), .word_out(w1), .word_p_out(p1),
      .index_out(i1), .last_out(l1), .busy_out(bz1));

   sm3_msg_expansion_stream #(.ROUNDS(1), .IDX_W(1), .PRELOAD(1)) dut_r1 (
      .clk_in(clk), .reset_in(rst), .msg_in(msg), .msg_valid_in(v2), .msg_ready_out(rdy2),
      .abort_in(a2), .word_valid_out(wv2), .word_ready_in(r2), .word_out(w2), .word_p_out(p2),
      .index_out(i2), .last_out(l2), .busy_out(bz2));

   always_comb begin
      m_ready = rdy0; m_wvalid = wv0; m_word = w0; m_wordp = p0; m_idx = i0; m_last = l0; m_busy = bz0;
      case (sel)
         1: begin m_ready = rdy1; m_wvalid = wv1; m_word = w1; m_wordp = p1; m_idx = i1; m_last = l1; m_busy = bz1; end
         2: begin m_ready = rdy2; m_wvalid = wv2; m_word = w2; m_wordp = p2; m_idx = {5'b0, i2}; m_last = l2; m_busy = bz2; end
         default: ;
      endcase
   end

   // Consumer ready: always taking, or a random 1/0 pattern while backpressure is enabled.
   always @(posedge clk) begin
      #1;
      b_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   int    n_vec = 0;
   int    n_err = 0;
   int    xfer_cnt = 0;
   beat_t exp_q[$];
   logic [31:0] cap_w [64];
   logic [31:0] cap_p [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x};
      return d[63-n -: 32];
   endfunction

   function automatic logic [31:0] pp1(input logic [31:0] x);
      return x ^ rotl(x, 15) ^ rotl(x, 23);
   endfunction

   // Textbook SM3 expansion W0..W67; pushes the expected beats of one block.
   task automatic push_block(input logic [511:0] m, input int rounds);
      logic [31:0] w [68];
      beat_t b;
      for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
      for (int j = 16; j < 68; j++)
         w[j] = pp1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
      for (int j = 0; j < rounds; j++) begin
         b.w = w[j]; b.wp = w[j] ^ w[j+4]; b.idx = 6'(j); b.last = (j == rounds - 1);
         exp_q.push_back(b);
      end
   endtask

   // Monitor: pops on every beat transfer and checks hold-stability across stalls.
   logic        stall_q = 1'b0;
   logic [71:0] prev_out = '0;
   always @(negedge clk) begin
      beat_t got, ex;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            n_vec++;
            if ({m_wvalid, m_word, m_wordp, m_idx, m_last} !== prev_out) begin
               n_err++;
               $display("FAIL stall_hold: got %h expected %h", {m_wvalid, m_word, m_wordp, m_idx, m_last}, prev_out);
            end
         end
         if (m_wvalid && b_ready) begin
            got = '{w: m_word, wp: m_wordp, idx: m_idx, last: m_last};
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL beat_unexpected: got %h expected none", got);
            end else begin
               ex = exp_q.pop_front();
               if (got !== ex) begin
                  n_err++;
                  $display("FAIL beat j=%0d: got %h expected %h", ex.idx, got, ex);
               end
            end
            if (sel == 0) begin
               cap_w[m_idx] = m_word;
               cap_p[m_idx] = m_wordp;
            end
            xfer_cnt++;
         end
         stall_q  = m_wvalid && !b_ready && !b_abort;
         prev_out = {m_wvalid, m_word, m_wordp, m_idx, m_last};
      end
   end

   task automatic send(input logic [511:0] m, output int acc_cnt);
      logic acc;
      acc = 1'b0;
      acc_cnt = -1;
      msg = m;
      b_valid = 1'b1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk); #1;
         if (m_ready) begin
            acc = 1'b1;
            acc_cnt = xfer_cnt;
            push_block(m, (sel == 2) ? 1 : 64);
            break;
         end
      end
      chk("block_accept", 32'(acc), 32'd1);
      @(posedge clk); #1;
      b_valid = 1'b0;
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && !m_wvalid) begin done = 1'b1; break; end
      end
      chk("drain", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic run_len(output int n);
      n = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk); #1;
         if (m_wvalid) n++;
         else if (n > 0) break;
      end
   endtask

   function automatic logic [511:0] mk_blk(input logic [31:0] seed);
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[511-32*i -: 32] = (seed * 32'(i + 1)) ^ rotl(seed, i + 3);
      return b;
   endfunction

   logic [511:0] abc, blk_b, blk_c, blk_d;
   int acc_a, acc_b, n_run;

   initial begin
      abc   = {32'h61626380, 448'h0, 32'h00000018};
      blk_b = mk_blk(32'h9E3779B9);
      blk_c = mk_blk(32'h1234ABCD);
      blk_d = mk_blk(32'hC0FFEE01);

      // Reset state
      #12;
      chk("rst_valid", 32'(m_wvalid), 32'd0);
      chk("rst_word", m_word, 32'h0);
      chk("rst_word_p", m_wordp, 32'h0);
      chk("rst_index", 32'(m_idx), 32'd0);
      chk("rst_last", 32'(m_last), 32'd0);
      chk("rst_busy", 32'(m_busy), 32'd0);
      chk("rst_ready", 32'(m_ready), 32'd1);
      #11 rst = 1'b0;
      @(posedge clk); #1;

      // "abc" block, consumer always ready
      xfer_cnt = 0;
      send(abc, acc_a);
      drain();
      chk("abc_beats", 32'(xfer_cnt), 32'd64);
      chk("abc_w0", cap_w[0], 32'h61626380);
      chk("abc_wp0", cap_p[0], 32'h61626380);
      chk("abc_wp12", cap_p[12], 32'h9092E200);
      chk("abc_w16", cap_w[16], 32'h9092E200);
      chk("abc_w18", cap_w[18], 32'h000C0606);
      chk("abc_end_busy", 32'(m_busy), 32'd0);

      // Random backpressure on the same block
      bp_en = 1'b1;
      xfer_cnt = 0;
      send(abc, acc_a);
      drain();
      bp_en = 1'b0;
      chk("bp_beats", 32'(xfer_cnt), 32'd64);
      @(posedge clk); #1;

      // Double buffering: second block lands in the shadow, no gap between blocks
      xfer_cnt = 0;
      send(abc, acc_a);
      send(blk_b, acc_b);
      chk("p1_early_accept", 32'(acc_b <= 2), 32'd1);
      chk("p1_ready_shadow_full", 32'(m_ready), 32'd0);
      run_len(n_run);
      chk("p1_zero_gap_run", 32'(n_run), 32'd128);
      drain();
      chk("p1_end_busy", 32'(m_busy), 32'd0);

      // Abort at beat 20 with the shadow full; a block offered in the abort cycle is dropped
      xfer_cnt = 0;
      send(blk_b, acc_a);
      send(abc, acc_b);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk); #1;
         if (xfer_cnt >= 20) break;
      end
      @(posedge clk); #1;
      chk("abort_pre_index", 32'(m_idx), 32'd20);
      b_abort = 1'b1;
      msg = blk_d;
      b_valid = 1'b1;
      @(negedge clk); #1;
      chk("abort_ready_low", 32'(m_ready), 32'd0);
      @(posedge clk); #1;
      b_abort = 1'b0;
      b_valid = 1'b0;
      exp_q.delete();
      @(negedge clk); #1;
      chk("abort_valid", 32'(m_wvalid), 32'd0);
      chk("abort_ready", 32'(m_ready), 32'd1);
      chk("abort_busy", 32'(m_busy), 32'd0);
      @(posedge clk); #1;
      send(blk_c, acc_a);
      drain();

      // Asynchronous reset in the middle of a block
      send(abc, acc_a);
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(m_wvalid), 32'd0);
      chk("mid_rst_word", m_word, 32'h0);
      chk("mid_rst_word_p", m_wordp, 32'h0);
      chk("mid_rst_index", 32'(m_idx), 32'd0);
      chk("mid_rst_last", 32'(m_last), 32'd0);
      chk("mid_rst_busy", 32'(m_busy), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;

      // No shadow: second block waits until the first has fully streamed
      sel = 1;
      xfer_cnt = 0;
      send(abc, acc_a);
      @(negedge clk); #1;
      chk("p0_ready_in_run", 32'(m_ready), 32'd0);
      @(posedge clk); #1;
      send(blk_b, acc_b);
      chk("p0_accept_after_64", 32'(acc_b), 32'd64);
      @(negedge clk); #1;
      chk("p0_gap_valid", 32'(m_wvalid), 32'd0);
      drain();
      chk("p0_beats", 32'(xfer_cnt), 32'd128);

      // ROUNDS=1: one beat per block, second block chained in on the final-beat cycle
      sel = 2;
      xfer_cnt = 0;
      send(abc, acc_a);
      send(blk_c, acc_b);
      run_len(n_run);
      chk("r1_run", 32'(n_run), 32'd2);
      drain();
      chk("r1_beats", 32'(xfer_cnt), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
